// File: rtl/ip_header_sequencer8.sv
// Byte-serial IPv4 header controller: tracks header position, gates the src/dst-IP
// section decoder, extracts protocol/total length, checks the header checksum and forwards payload.
module ip_header_sequencer8 #(
    parameter int AVL_SIZE      = 8,
    parameter int SEC_FIRST     = 12,
    parameter int SEC_WORDS     = 8,
    parameter int MAX_IHL_BYTES = 60
) (
    input  logic                clk,
    input  logic                async_reset_n,
    input  logic                sof,
    input  logic                data_in_valid,
    input  logic [AVL_SIZE-1:0] data_in,
    input  logic                abort,
    output logic                sec_reset,
    output logic                sec_valid,
    output logic [AVL_SIZE-1:0] sec_data,
    output logic [7:0]          protocol,
    output logic [15:0]         total_length,
    output logic                hdr_done,
    output logic                hdr_ok,
    output logic                err_version,
    output logic                err_checksum,
    output logic                payload_valid,
    output logic [AVL_SIZE-1:0] payload_data
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;

    localparam logic [5:0] SEC_LO  = 6'(SEC_FIRST);
    localparam logic [5:0] SEC_HI  = 6'(SEC_FIRST + SEC_WORDS - 1);
    localparam logic [5:0] MAX_HDR = 6'(MAX_IHL_BYTES);

    state_t              state_q, state_d;
    logic [5:0]          byte_cnt_q, byte_cnt_d;
    logic [3:0]          ihl_q, ihl_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         acc_q, acc_d;
    logic [15:0]         remaining_q, remaining_d;
    logic                sec_reset_q, sec_reset_d;
    logic                sec_valid_q, sec_valid_d;
    logic [AVL_SIZE-1:0] sec_data_q, sec_data_d;
    logic [7:0]          protocol_q, protocol_d;
    logic [15:0]         total_length_q, total_length_d;
    logic                hdr_done_q, hdr_done_d;
    logic                hdr_ok_q, hdr_ok_d;
    logic                err_version_q, err_version_d;
    logic                err_checksum_q, err_checksum_d;
    logic                payload_valid_q, payload_valid_d;
    logic [AVL_SIZE-1:0] payload_data_q, payload_data_d;

    logic [16:0] acc_sum;
    logic [15:0] acc_fold;
    logic [5:0]  hdr_last;
    logic [15:0] hdr_len;
    logic        hdr_good;

    always_comb begin
        // One ones'-complement add of {hi, lo} never needs more than one carry fold.
        acc_sum  = {1'b0, acc_q} + {1'b0, hi_q, data_in};
        acc_fold = acc_sum[15:0] + {15'd0, acc_sum[16]};
        hdr_last = {ihl_q, 2'b00} - 6'd1;
        hdr_len  = {10'd0, ihl_q, 2'b00};
        hdr_good = (acc_fold == 16'hFFFF) && !err_version_q && (total_length_q >= hdr_len);

        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        ihl_d           = ihl_q;
        hi_d            = hi_q;
        acc_d           = acc_q;
        remaining_d     = remaining_q;
        sec_reset_d     = 1'b0;
        sec_valid_d     = 1'b0;
        sec_data_d      = sec_data_q;
        protocol_d      = protocol_q;
        total_length_d  = total_length_q;
        hdr_done_d      = 1'b0;
        hdr_ok_d        = 1'b0;
        err_version_d   = err_version_q;
        err_checksum_d  = err_checksum_q;
        payload_valid_d = 1'b0;
        payload_data_d  = payload_data_q;

        if (abort) begin
            state_d = IDLE;
        end else if (data_in_valid && sof) begin
            state_d        = HEADER;
            byte_cnt_d     = 6'd1;
            ihl_d          = data_in[3:0];
            hi_d           = data_in;
            acc_d          = 16'd0;
            remaining_d    = 16'd0;
            sec_reset_d    = 1'b1;
            err_version_d  = 1'b0;
            err_checksum_d = 1'b0;
            if ((data_in[7:4] != 4'd4) || (data_in[3:0] < 4'd5) ||
                ({data_in[3:0], 2'b00} > MAX_HDR)) begin
                err_version_d = 1'b1;
                hdr_done_d    = 1'b1;
                state_d       = DROP;
            end
        end else if (data_in_valid) begin
            case (state_q)
                HEADER: begin
                    byte_cnt_d = byte_cnt_q + 6'd1;
                    if (byte_cnt_q == 6'd2) total_length_d[15:8] = data_in;
                    if (byte_cnt_q == 6'd3) total_length_d[7:0]  = data_in;
                    if (byte_cnt_q == 6'd9) protocol_d           = data_in;
                    if ((byte_cnt_q >= SEC_LO) && (byte_cnt_q <= SEC_HI)) begin
                        sec_valid_d = 1'b1;
                        sec_data_d  = data_in;
                    end
                    if (!byte_cnt_q[0]) hi_d = data_in;
                    else                acc_d = acc_fold;
                    if (byte_cnt_q == hdr_last) begin
                        hdr_done_d     = 1'b1;
                        hdr_ok_d       = hdr_good;
                        err_checksum_d = (acc_fold != 16'hFFFF);
                        if (hdr_good && (total_length_q > hdr_len)) begin
                            state_d     = PAYLOAD;
                            remaining_d = total_length_q - hdr_len;
                        end else if (hdr_good) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    payload_valid_d = 1'b1;
                    payload_data_d  = data_in;
                    remaining_d     = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q         <= IDLE;
            byte_cnt_q      <= 6'd0;
            ihl_q           <= 4'd0;
            hi_q            <= 8'd0;
            acc_q           <= 16'd0;
            remaining_q     <= 16'd0;
            sec_reset_q     <= 1'b0;
            sec_valid_q     <= 1'b0;
            sec_data_q      <= '0;
            protocol_q      <= 8'd0;
            total_length_q  <= 16'd0;
            hdr_done_q      <= 1'b0;
            hdr_ok_q        <= 1'b0;
            err_version_q   <= 1'b0;
            err_checksum_q  <= 1'b0;
            payload_valid_q <= 1'b0;
            payload_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            ihl_q           <= ihl_d;
            hi_q            <= hi_d;
            acc_q           <= acc_d;
            remaining_q     <= remaining_d;
            sec_reset_q     <= sec_reset_d;
            sec_valid_q     <= sec_valid_d;
            sec_data_q      <= sec_data_d;
            protocol_q      <= protocol_d;
            total_length_q  <= total_length_d;
            hdr_done_q      <= hdr_done_d;
            hdr_ok_q        <= hdr_ok_d;
            err_version_q   <= err_version_d;
            err_checksum_q  <= err_checksum_d;
            payload_valid_q <= payload_valid_d;
            payload_data_q  <= payload_data_d;
        end
    end

    assign sec_reset     = sec_reset_q;
    assign sec_valid     = sec_valid_q;
    assign sec_data      = sec_data_q;
    assign protocol      = protocol_q;
    assign total_length  = total_length_q;
    assign hdr_done      = hdr_done_q;
    assign hdr_ok        = hdr_ok_q;
    assign err_version   = err_version_q;
    assign err_checksum  = err_checksum_q;
    assign payload_valid = payload_valid_q;
    assign payload_data  = payload_data_q;

endmodule

// File: doc/ip_header_sequencer8.md
Name: ip_header_sequencer8

Overview:
Byte-serial IPv4 header controller for the 8-bit UDP receive core. It tracks the byte position inside the IPv4 header and gates the 8-byte src/dst-IP section decoder so that only header bytes 12..19 are shifted into it. It also extracts version, IHL, protocol and total length, verifies the header checksum, and forwards the IP payload bytes downstream. It sits between the Ethernet/MAC stripper and the IP section decoder / UDP decoder.

Parameters:
AVL_SIZE, 8, data bus width in bits (only 8 supported)
SEC_FIRST, 12, header byte index of the first src/dst-IP byte
SEC_WORDS, 8, number of bytes routed to the section decoder
MAX_IHL_BYTES, 60, maximum header length accepted

Ports:
clk  in  1  core clock
async_reset_n  in  1  asynchronous active-low reset
sof  in  1  qualifies data_in as byte 0 of an IP header
data_in_valid  in  1  data_in valid strobe
data_in  in  8  header/payload byte stream
abort  in  1  drop current packet (MAC error / FCS fail)
sec_reset  out  1  one-cycle sync clear pulse to the section decoder
sec_valid  out  1  data_in_valid to the section decoder
sec_data  out  8  byte to the section decoder
protocol  out  8  IP protocol field
total_length  out  16  IP total length field
hdr_done  out  1  one-cycle pulse: header fully received
hdr_ok  out  1  status qualified by hdr_done
err_version  out  1  sticky until next sof: version!=4 or IHL<5
err_checksum  out  1  sticky until next sof: checksum mismatch
payload_valid  out  1  payload byte strobe
payload_data  out  8  payload byte

Behaviour:
- All outputs registered; 1-cycle latency from an accepted input byte. Reset: every output 0, state IDLE, counters 0.
- States: IDLE, HEADER, PAYLOAD, DROP.
- IDLE: on sof&data_in_valid, byte index 0 is taken, sec_reset pulses, error flags clear, state -> HEADER. Bytes without sof are ignored.
- HEADER: byte_cnt (6 bit) increments per valid byte. Byte 0 latches version/IHL; byte 1 is ignored; bytes 2-3 latch total_length (MSB first); byte 9 latches protocol. On bytes SEC_FIRST..SEC_FIRST+SEC_WORDS-1, sec_valid=1 and sec_data=byte.
- Version check at byte 0: version!=4 or IHL<5 sets err_version and forces state DROP. hdr_done pulses with hdr_ok=0.
- Checksum: even-index bytes are held as the high byte. Each odd-index byte adds {hi,lo} to a 16-bit ones'-complement accumulator with end-around carry, folded every cycle. After byte IHL*4-1, accumulator!=16'hFFFF sets err_checksum.
- Header end at byte IHL*4-1: hdr_done pulses the next cycle, with hdr_ok = !err_version & !err_checksum & (total_length >= IHL*4).
  - If hdr_ok and total_length > IHL*4: state -> PAYLOAD, remaining = total_length - IHL*4 (16-bit).
  - If hdr_ok and total_length == IHL*4: state -> IDLE.
  - Otherwise: state -> DROP.
- PAYLOAD: each valid byte is forwarded as payload_valid/payload_data and remaining decrements. On the byte where remaining==1, state -> IDLE. Trailing bytes such as Ethernet padding are ignored in IDLE.
- DROP: all bytes are ignored. The state leaves only on sof (treated as a new header, same as in IDLE).
- sof in HEADER/PAYLOAD/DROP: the current packet ends silently (no hdr_done if still in HEADER) and a new header starts at byte 0.
- abort in any state: state -> IDLE next cycle, with no further sec_valid/payload_valid. abort wins over a simultaneous sof.
- data_in_valid low: no state or counter change; gaps are allowed anywhere.
- Asynchronous reset mid-packet: immediate return to the reset state. The next packet requires sof.

Test Plan:
- Header 45 00 00 1C 00 00 40 00 40 11 B7 75 C0 A8 01 0A C0 A8 01 01 plus 8 payload bytes, contiguous -> sec_valid for exactly 8 cycles carrying C0 A8 01 0A C0 A8 01 01; protocol=0x11; total_length=28; hdr_done with hdr_ok=1 one cycle after byte 19; 8 payload_valid strobes.
- Same frame with checksum B7 76 -> err_checksum=1, hdr_ok=0, zero payload_valid strobes.
- First byte 0x46 (IHL=6, 4 option bytes, checksum recomputed, total_length 32) -> sec bytes still indices 12..19; hdr_done after byte 23; 8 payload bytes.
- First byte 0x65 -> err_version=1 and hdr_done/hdr_ok=0 one cycle later; rest of frame ignored; a following good frame with sof is decoded correctly.
- Valid frame with data_in_valid toggling every other cycle plus 6 padding bytes -> same outputs as the contiguous case, padding not forwarded.
- abort asserted at header byte 14, then async_reset_n pulsed mid-payload of the next frame -> sec_valid stops after byte 13 with no hdr_done; after the reset pulse all outputs are 0 and the next sof frame decodes normally.
